// File: rtl/minterm_enum_if.sv
// Minterm stream bundle: start/truth-table request plus valid/ready minterm output.
// The m_count sideband exists only when MINTERM_COUNT_EN is defined.
interface minterm_enum_if #(
  parameter int N = 3
);
  logic             start;
  logic [(1<<N)-1:0] tt;
  logic             busy;
  logic             m_valid;
  logic             m_ready;
  logic [N-1:0]     m_idx;
  logic             m_last;
  logic             done;
`ifdef MINTERM_COUNT_EN
  logic [N:0]       m_count;
`endif

  modport master (
    input  start, tt, m_ready,
`ifdef MINTERM_COUNT_EN
    output m_count,
`endif
    output busy, m_valid, m_idx, m_last, done
  );

  modport slave (
    output start, tt, m_ready,
`ifdef MINTERM_COUNT_EN
    input  m_count,
`endif
    input  busy, m_valid, m_idx, m_last, done
  );
endinterface

// File: rtl/minterm_enum.sv
// Serially emits every set index of a captured truth table, ascending order.
// Optional feature: define MINTERM_COUNT_EN to add the m_count popcount output.
module minterm_enum #(
  parameter int N = 3
) (
  input  logic          clk,
  input  logic          rst,
  minterm_enum_if.master bus
);
  localparam int W = 1 << N;
  localparam logic [N-1:0] IMAX = '1;
  localparam logic [N-1:0] I1 = 1;
  localparam logic [N:0]   S1 = 1;

  typedef enum logic [1:0] {
    IDLE, SCAN, EMIT, DONE
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   tt_q, tt_d;
  logic [N-1:0]   i_q, i_d;
  logic [N-1:0]   m_idx_q, m_idx_d;
  logic           m_valid_q, m_valid_d;
  logic           m_last_q, m_last_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [N:0]     sh;

  always_comb begin
    state_d   = state_q;
    tt_d      = tt_q;
    i_d       = i_q;
    m_idx_d   = m_idx_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    sh        = {1'b0, i_q} + S1;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          tt_d    = bus.tt;
          i_d     = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (tt_q[i_q]) begin
          m_idx_d   = i_q;
          m_valid_d = 1'b1;
          // shift at full table width: index 2**N-1 shifts everything out
          m_last_d  = ((tt_q >> sh) == '0);
          state_d   = EMIT;
        end else if (i_q == IMAX) begin
          state_d = DONE;
        end else begin
          i_d = i_q + I1;
        end
      end
      EMIT: begin
        if (m_valid_q && bus.m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          if (m_last_q) begin
            state_d = DONE;
          end else begin
            i_d     = i_q + I1;
            state_d = SCAN;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SCAN) || (state_d == EMIT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tt_q      <= '0;
      i_q       <= '0;
      m_idx_q   <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tt_q      <= tt_d;
      i_q       <= i_d;
      m_idx_q   <= m_idx_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_idx   = m_idx_q;
  assign bus.m_last  = m_last_q;
  assign bus.done    = done_q;

`ifdef MINTERM_COUNT_EN
  logic [N:0] cnt_q, pop;

  always_comb begin
    pop = '0;
    for (int b = 0; b < W; b++) begin
      pop = pop + {{N{1'b0}}, bus.tt[b]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == IDLE && bus.start) begin
      cnt_q <= pop;
    end
  end

  assign bus.m_count = cnt_q;
`endif
endmodule

// File: tb/tb_minterm_enum.sv
// Directed bench for minterm_enum (N=3) with hand-computed minterm lists.
// Define MINTERM_COUNT_EN to also check the popcount output.
module tb_minterm_enum;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;
  int   got_q[$];
  int   first_cyc;
  int   done_cyc;
  int   done_cnt;

  minterm_enum_if #(.N(3)) bus ();

  minterm_enum #(.N(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 0);
    chk({tag, "_valid"}, {31'd0, bus.m_valid}, 0);
    chk({tag, "_idx"}, {29'd0, bus.m_idx}, 0);
    chk({tag, "_last"}, {31'd0, bus.m_last}, 0);
    chk({tag, "_done"}, {31'd0, bus.done}, 0);
`ifdef MINTERM_COUNT_EN
    chk({tag, "_cnt"}, {28'd0, bus.m_count}, 0);
`endif
  endtask

  // exp packs {last,idx} per nibble, first minterm in the low nibble
  task automatic run(input string tag, input logic [7:0] t,
                     input int rmode, input int n,
                     input logic [31:0] exp, input int efirst,
                     input int edone, input int ecnt);
    int cyc;
    logic hv;
    logic [3:0] hval;
    got_q.delete();
    first_cyc = -1;
    done_cyc  = -1;
    done_cnt  = 0;
    bus.tt    = t;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.tt    = ~t;
    chk({tag, "_busy"}, {31'd0, bus.busy}, 1);
    cyc = 0;
    while (cyc < 60 && !(done_cyc >= 0 && cyc > done_cyc + 2)) begin
      if (rmode == 0) bus.m_ready = 1'b1;
      else bus.m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      bus.start = (rmode != 0) && bus.busy && (cyc % 3 == 1);
      if (bus.m_valid && bus.m_ready)
        got_q.push_back({28'd0, bus.m_last, bus.m_idx});
      hv   = bus.m_valid && !bus.m_ready;
      hval = {bus.m_last, bus.m_idx};
      tick();
      cyc++;
      if (hv)
        chk({tag, "_hold"}, {27'd0, bus.m_valid, bus.m_last, bus.m_idx},
            {27'd0, 1'b1, hval});
      if (bus.m_valid && first_cyc < 0) first_cyc = cyc;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
    end
    bus.start = 1'b0;
    chk({tag, "_n"}, got_q.size(), n);
    for (int k = 0; k < got_q.size() && k < n; k++)
      chk({tag, "_mt"}, got_q[k], (exp >> (4 * k)) & 32'hF);
    chk({tag, "_donecnt"}, done_cnt, 1);
    if (efirst != -2) chk({tag, "_first"}, first_cyc, efirst);
    if (edone >= 0) chk({tag, "_donecyc"}, done_cyc, edone);
    chk({tag, "_idle"}, {31'd0, bus.busy}, 0);
`ifdef MINTERM_COUNT_EN
    chk({tag, "_cnt"}, {28'd0, bus.m_count}, ecnt);
`else
    if (ecnt < 0) chk({tag, "_cnt"}, 0, 0);
`endif
  endtask

  initial begin
    int c;
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.tt = 8'h00;
    bus.m_ready = 1'b0;
    repeat (2) tick();
    chk_reset("rst");
    rst = 1'b0;
    tick();

    run("f1", 8'h8B, 0, 4, 32'h0000_F310, 1, 12, 4);
    run("zero", 8'h00, 0, 0, 32'h0, -1, 8, 0);
    run("ff", 8'hFF, 1, 8, 32'hF654_3210, 1, -1, 8);
    run("top", 8'h80, 0, 1, 32'h0000_000F, 8, 9, 1);

    bus.m_ready = 1'b0;
    bus.tt = 8'h8B;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    c = 0;
    while (c < 20 && !bus.m_valid) begin
      tick();
      c++;
    end
    chk("mid_v0", {28'd0, bus.m_valid, bus.m_idx}, {28'd0, 1'b1, 3'd0});
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    c = 0;
    while (c < 20 && !bus.m_valid) begin
      tick();
      c++;
    end
    chk("mid_v1", {28'd0, bus.m_valid, bus.m_idx}, {28'd0, 1'b1, 3'd1});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("mid");
    tick();
    chk("mid_nodone", {31'd0, bus.done}, 0);
    run("fresh", 8'h02, 0, 1, 32'h0000_0009, 2, 3, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
